// File: rtl/prog_loader.sv
// Byte-stream program loader: frames SYNC/LEN/words/CSUM into program memory
// and holds the CPU in reset until a frame with a good checksum completes.
module prog_loader #(
    parameter int          ADDR_W    = 10,
    parameter int          MAX_WORDS = 1024,
    parameter logic [7:0]  SYNC      = 8'hA5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              pm_we,
    output logic [ADDR_W-1:0] pm_addr,
    output logic [31:0]       pm_wdata,
    output logic              cpu_rst,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   words_loaded
);

    localparam int              CW      = ADDR_W + 1;
    localparam logic [CW-1:0]   ONE     = CW'(1);
    localparam logic [15:0]     MAX_LEN = 16'(MAX_WORDS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    state_t        state;
    state_t        state_nxt;

    logic          acc;
    logic          is_sync;
    logic [7:0]    len_hi;
    logic [15:0]   len_in;
    logic          len_ok;
    logic [CW-1:0] len_q;
    logic [CW-1:0] word_cnt;
    logic [1:0]    byte_idx;
    logic [23:0]   word_sr;
    logic [7:0]    csum;
    logic          last_byte;
    logic          last_word;
    logic          csum_ok;

    // The loader never back-pressures the byte source.
    assign in_ready  = 1'b1;
    assign acc       = in_valid && in_ready;
    assign is_sync   = (in_data == SYNC);
    assign len_in    = {len_hi, in_data};
    assign len_ok    = (len_in != 16'd0) && (len_in <= MAX_LEN);
    assign last_byte = (byte_idx == 2'd3);
    assign last_word = (word_cnt == (len_q - ONE));
    assign csum_ok   = (in_data == csum);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (acc) begin
            unique case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (is_sync) begin
                        state_nxt = S_LEN_HI;
                    end
                end
                S_LEN_HI: state_nxt = S_LEN_LO;
                S_LEN_LO: state_nxt = len_ok ? S_DATA : S_ERR;
                S_DATA: begin
                    if (last_byte && last_word) begin
                        state_nxt = S_CSUM;
                    end
                end
                S_CSUM:   state_nxt = csum_ok ? S_DONE : S_ERR;
                default:  state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pm_we        <= 1'b0;
            pm_addr      <= '0;
            pm_wdata     <= '0;
            cpu_rst      <= 1'b1;
            done         <= 1'b0;
            err          <= 1'b0;
            words_loaded <= '0;
            len_hi       <= '0;
            len_q        <= '0;
            word_cnt     <= '0;
            byte_idx     <= '0;
            word_sr      <= '0;
            csum         <= '0;
        end else begin
            pm_we <= 1'b0;
            if (acc) begin
                unique case (state)
                    S_IDLE, S_DONE, S_ERR: begin
                        if (is_sync) begin
                            cpu_rst <= 1'b1;
                            done    <= 1'b0;
                            err     <= 1'b0;
                        end
                    end
                    S_LEN_HI: begin
                        len_hi <= in_data;
                    end
                    S_LEN_LO: begin
                        if (len_ok) begin
                            len_q        <= len_in[CW-1:0];
                            word_cnt     <= '0;
                            byte_idx     <= '0;
                            csum         <= '0;
                            words_loaded <= '0;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                    S_DATA: begin
                        byte_idx <= byte_idx + 2'd1;
                        csum     <= csum ^ in_data;
                        word_sr  <= {word_sr[15:0], in_data};
                        // Fourth byte completes the word: write it next cycle.
                        if (last_byte) begin
                            pm_we        <= 1'b1;
                            pm_addr      <= word_cnt[ADDR_W-1:0];
                            pm_wdata     <= {word_sr, in_data};
                            word_cnt     <= word_cnt + ONE;
                            words_loaded <= words_loaded + ONE;
                        end
                    end
                    S_CSUM: begin
                        if (csum_ok) begin
                            done    <= 1'b1;
                            cpu_rst <= 1'b0;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Directed testbench for prog_loader: framed loads, checksum and length
// errors, noise rejection, restart from DONE and reset mid-frame.
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        pm_we;
    logic [9:0]  pm_addr;
    logic [31:0] pm_wdata;
    logic        cpu_rst;
    logic        done;
    logic        err;
    logic [10:0] words_loaded;

    int n_tests = 0;
    int n_fail  = 0;
    int wr_cnt  = 0;
    int base;
    logic [9:0]  wr_addr [0:63];
    logic [31:0] wr_data [0:63];

    prog_loader dut (
        .clk          (clk),
        .rst          (rst),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .pm_we        (pm_we),
        .pm_addr      (pm_addr),
        .pm_wdata     (pm_wdata),
        .cpu_rst      (cpu_rst),
        .done         (done),
        .err          (err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    // Record every write strobe; a level held two cycles records twice.
    always @(negedge clk) begin
        if (pm_we) begin
            wr_addr[wr_cnt % 64] = pm_addr;
            wr_data[wr_cnt % 64] = pm_wdata;
            wr_cnt = wr_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        in_data  = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[31:24]);
        send_byte(w[23:16]);
        send_byte(w[15:8]);
        send_byte(w[7:0]);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        do_reset();
        check("rst_in_ready", in_ready, 1);
        check("rst_pm_we", pm_we, 0);
        check("rst_pm_addr", pm_addr, 0);
        check("rst_pm_wdata", pm_wdata, 0);
        check("rst_cpu_rst", cpu_rst, 1);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_words", words_loaded, 0);

        // 1: single word load
        base = wr_cnt;
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01);
        send_word(32'h10800005);
        check("t1_we", pm_we, 1);
        check("t1_addr", pm_addr, 0);
        check("t1_wdata", pm_wdata, 32'h10800005);
        send_byte(8'h95);
        check("t1_done", done, 1);
        check("t1_cpu_rst", cpu_rst, 0);
        check("t1_err", err, 0);
        check("t1_words", words_loaded, 1);
        check("t1_nwr", wr_cnt - base, 1);
        // SYNC presented without valid must not restart
        @(negedge clk);
        in_data = 8'hA5;
        idle(2);
        check("t1_novalid_done", done, 1);
        check("t1_novalid_cpu", cpu_rst, 0);

        // 2: restart from DONE into a two-word load
        base = wr_cnt;
        send_byte(8'hA5);
        check("t2_restart_cpu", cpu_rst, 1);
        check("t2_restart_done", done, 0);
        send_byte(8'h00); send_byte(8'h02);
        send_word(32'hC0000000);
        send_word(32'hF0000000);
        send_byte(8'h30);
        check("t2_nwr", wr_cnt - base, 2);
        check("t2_addr0", wr_addr[base % 64], 0);
        check("t2_data0", wr_data[base % 64], 32'hC0000000);
        check("t2_addr1", wr_addr[(base + 1) % 64], 1);
        check("t2_data1", wr_data[(base + 1) % 64], 32'hF0000000);
        check("t2_done", done, 1);
        check("t2_words", words_loaded, 2);
        check("t2_hold_addr", pm_addr, 1);

        // 3: bad checksum
        base = wr_cnt;
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01);
        send_word(32'h10800005);
        send_byte(8'h00);
        check("t3_nwr", wr_cnt - base, 1);
        check("t3_err", err, 1);
        check("t3_done", done, 0);
        check("t3_cpu_rst", cpu_rst, 1);

        // 4: zero and oversize length, then the largest legal length
        base = wr_cnt;
        send_byte(8'hA5);
        check("t4_err_clr", err, 0);
        send_byte(8'h00); send_byte(8'h00);
        check("t4_len0_err", err, 1);
        send_byte(8'hA5); send_byte(8'h04); send_byte(8'h01);
        check("t4_len1025_err", err, 1);
        idle(2);
        check("t4_nwr", wr_cnt - base, 0);
        send_byte(8'hA5); send_byte(8'h04); send_byte(8'h00);
        check("t4_len1024_ok", err, 0);
        check("t4_len1024_cpu", cpu_rst, 1);

        // 5: noise ignored, load, then SYNC in DONE
        do_reset();
        base = wr_cnt;
        send_byte(8'h00); send_byte(8'hFF); send_byte(8'h12);
        check("t5_noise_err", err, 0);
        check("t5_noise_done", done, 0);
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01);
        send_word(32'h10800005);
        send_byte(8'h95);
        check("t5_done", done, 1);
        check("t5_cpu_rst", cpu_rst, 0);
        check("t5_nwr", wr_cnt - base, 1);
        send_byte(8'h12);
        check("t5_ign_done", done, 1);
        send_byte(8'hA5);
        check("t5_re_cpu", cpu_rst, 1);
        check("t5_re_done", done, 0);

        // 6: reset mid-frame
        do_reset();
        base = wr_cnt;
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01);
        send_byte(8'h10); send_byte(8'h80);
        do_reset();
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01);
        send_word(32'h12345678);
        send_byte(8'h12 ^ 8'h34 ^ 8'h56 ^ 8'h78);
        check("t6_nwr", wr_cnt - base, 1);
        check("t6_addr", wr_addr[base % 64], 0);
        check("t6_data", wr_data[base % 64], 32'h12345678);
        check("t6_done", done, 1);

        // 7: SYNC value inside payload is data
        do_reset();
        base = wr_cnt;
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01);
        send_word(32'hA5A5A5A5);
        send_byte(8'h00);
        check("t7_data", wr_data[base % 64], 32'hA5A5A5A5);
        check("t7_done", done, 1);
        check("t7_words", words_loaded, 1);

        idle(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
